// File: rtl/lcd_timing_pkg.sv
// Shared types for the RGB565 LCD driver: panel timing record, FSM states and the
// panel-ID to timing lookup.
package lcd_timing_pkg;

   localparam int unsigned CntW = 11;

   typedef logic [CntW-1:0] cnt_t;

   typedef struct packed {
      cnt_t hs;
      cnt_t hb;
      cnt_t hd;
      cnt_t hf;
      cnt_t vs;
      cnt_t vb;
      cnt_t vd;
      cnt_t vf;
   } timing_t;

   typedef enum logic [1:0] {
      StWait,
      StLatch,
      StRun
   } state_e;

   localparam logic [2:0] ID_4342 = 3'b000;
   localparam logic [2:0] ID_7084 = 3'b001;
   localparam logic [2:0] ID_7016 = 3'b010;
   localparam logic [2:0] ID_4384 = 3'b100;
   localparam logic [2:0] ID_1018 = 3'b101;

   localparam timing_t Timing4342 = '{hs: 11'd41,  hb: 11'd2,   hd: 11'd480,  hf: 11'd2,
                                      vs: 11'd10,  vb: 11'd2,   vd: 11'd272,  vf: 11'd2};
   localparam timing_t Timing7084 = '{hs: 11'd128, hb: 11'd88,  hd: 11'd800,  hf: 11'd40,
                                      vs: 11'd2,   vb: 11'd33,  vd: 11'd480,  vf: 11'd10};
   localparam timing_t Timing7016 = '{hs: 11'd20,  hb: 11'd140, hd: 11'd1024, hf: 11'd160,
                                      vs: 11'd3,   vb: 11'd20,  vd: 11'd600,  vf: 11'd12};
   localparam timing_t Timing1018 = '{hs: 11'd10,  hb: 11'd80,  hd: 11'd1280, hf: 11'd70,
                                      vs: 11'd3,   vb: 11'd10,  vd: 11'd800,  vf: 11'd10};

   function automatic logic id_known(logic [2:0] id);
      case (id)
         ID_4342, ID_7084, ID_7016, ID_4384, ID_1018: return 1'b1;
         default:                                     return 1'b0;
      endcase
   endfunction

   function automatic timing_t table_entry(logic [2:0] id);
      case (id)
         ID_7084, ID_4384: return Timing7084;
         ID_7016:          return Timing7016;
         ID_1018:          return Timing1018;
         default:          return Timing4342;
      endcase
   endfunction

   // An unlisted default_id itself falls back to the 4.3" 480x272 entry.
   function automatic timing_t id_to_timing(logic [2:0] id, logic [2:0] default_id);
      return id_known(id) ? table_entry(id) : table_entry(default_id);
   endfunction

endpackage

// File: rtl/lcd_rgb_driver_if.sv
// Pixel-requester and LCD-pin signals of the RGB565 driver; master is the driver side.
interface lcd_rgb_driver_if;

   logic [15:0] pixel_data;
   logic        data_req;
   logic [10:0] pixel_xpos;
   logic [10:0] pixel_ypos;
   logic [10:0] h_disp;
   logic [10:0] v_disp;
   logic        frame_start;
   logic        lcd_hs;
   logic        lcd_vs;
   logic        lcd_de;
   logic [15:0] lcd_rgb;
   logic        lcd_oe;
   logic        lcd_bl;

   modport master (
      input  pixel_data,
      output data_req,
      output pixel_xpos,
      output pixel_ypos,
      output h_disp,
      output v_disp,
      output frame_start,
      output lcd_hs,
      output lcd_vs,
      output lcd_de,
      output lcd_rgb,
      output lcd_oe,
      output lcd_bl
   );

   modport slave (
      output pixel_data,
      input  data_req,
      input  pixel_xpos,
      input  pixel_ypos,
      input  h_disp,
      input  v_disp,
      input  frame_start,
      input  lcd_hs,
      input  lcd_vs,
      input  lcd_de,
      input  lcd_rgb,
      input  lcd_oe,
      input  lcd_bl
   );

endinterface

// File: rtl/lcd_hv_counter.sv
// Horizontal/vertical position counters with sync and active-window decodes for the
// currently loaded panel timing. Counters sit at 0 while en is low.
module lcd_hv_counter
   import lcd_timing_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    en,
   input  timing_t timing,
   output logic    hsync_act,
   output logic    vsync_act,
   output logic    active,
   output logic    origin,
   output cnt_t    xpos,
   output cnt_t    ypos
);

   cnt_t h_cnt_q, v_cnt_q;
   cnt_t h_total, v_total;
   cnt_t h_start, h_end, v_start, v_end;
   logic h_last, v_last;

   always_comb begin
      h_total = timing.hs + timing.hb + timing.hd + timing.hf;
      v_total = timing.vs + timing.vb + timing.vd + timing.vf;
      // Requests lead lcd_de by one cycle, hence the window opens one column early.
      h_start = timing.hs + timing.hb - 11'd1;
      h_end   = h_start + timing.hd;
      v_start = timing.vs + timing.vb;
      v_end   = v_start + timing.vd;
      h_last  = (h_cnt_q >= h_total - 11'd1);
      v_last  = (v_cnt_q >= v_total - 11'd1);
   end

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else if (h_last) begin
         h_cnt_q <= '0;
         v_cnt_q <= v_last ? '0 : v_cnt_q + 11'd1;
      end else begin
         h_cnt_q <= h_cnt_q + 11'd1;
      end
   end

   always_comb begin
      hsync_act = (h_cnt_q < timing.hs);
      vsync_act = (v_cnt_q < timing.vs);
      active    = (h_cnt_q >= h_start) && (h_cnt_q < h_end) &&
                  (v_cnt_q >= v_start) && (v_cnt_q < v_end);
      origin    = (h_cnt_q == '0) && (v_cnt_q == '0);
      xpos      = h_cnt_q - h_start;
      ypos      = v_cnt_q - v_start;
   end

endmodule

// File: rtl/lcd_rgb_driver.sv
// RGB565 LCD panel driver: holds the bus released while the panel ID straps settle,
// latches the ID once, then generates sync/DE timing and registered pixel output.
module lcd_rgb_driver
   import lcd_timing_pkg::*;
#(
   parameter int unsigned ID_WAIT    = 8,
   parameter logic [2:0]  DEFAULT_ID = 3'b000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       panel_id,
   lcd_rgb_driver_if.master bus
);

   localparam int unsigned WaitW = $clog2(ID_WAIT);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(ID_WAIT - 1);

   state_e           state_q;
   logic [WaitW-1:0] wait_q;
   timing_t          timing_q;
   logic             oe_q, bl_q;

   logic        run;
   logic        hsync_act, vsync_act, active, origin;
   cnt_t        xpos, ypos;
   logic        data_req;
   logic        de_q, hs_q, vs_q, fs_q;
   logic [15:0] rgb_q;

   // Timing is loaded exactly once; RUN has no exit short of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StWait;
         wait_q   <= '0;
         timing_q <= id_to_timing(DEFAULT_ID, DEFAULT_ID);
         oe_q     <= 1'b0;
         bl_q     <= 1'b0;
      end else begin
         case (state_q)
            StWait: begin
               if (wait_q == WaitLast) begin
                  state_q <= StLatch;
               end else begin
                  wait_q <= wait_q + WaitW'(1);
               end
            end
            StLatch: begin
               timing_q <= id_to_timing(panel_id, DEFAULT_ID);
               state_q  <= StRun;
               oe_q     <= 1'b1;
               bl_q     <= 1'b1;
            end
            StRun: begin
               state_q <= StRun;
            end
            default: begin
               state_q <= StWait;
            end
         endcase
      end
   end

   assign run = (state_q == StRun);

   lcd_hv_counter u_hv_counter (
      .clk       (clk),
      .rst       (rst),
      .en        (run),
      .timing    (timing_q),
      .hsync_act (hsync_act),
      .vsync_act (vsync_act),
      .active    (active),
      .origin    (origin),
      .xpos      (xpos),
      .ypos      (ypos)
   );

   assign data_req = run && active;

   // Syncs stay deasserted until RUN so the panel sees an idle bus while released.
   always_ff @(posedge clk) begin
      if (rst) begin
         de_q  <= 1'b0;
         rgb_q <= '0;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         fs_q  <= 1'b0;
      end else begin
         de_q  <= data_req;
         rgb_q <= data_req ? bus.pixel_data : '0;
         hs_q  <= !(run && hsync_act);
         vs_q  <= !(run && vsync_act);
         fs_q  <= run && origin;
      end
   end

   assign bus.data_req    = data_req;
   assign bus.pixel_xpos  = data_req ? xpos : '0;
   assign bus.pixel_ypos  = data_req ? ypos : '0;
   assign bus.h_disp      = timing_q.hd;
   assign bus.v_disp      = timing_q.vd;
   assign bus.frame_start = fs_q;
   assign bus.lcd_hs      = hs_q;
   assign bus.lcd_vs      = vs_q;
   assign bus.lcd_de      = de_q;
   assign bus.lcd_rgb     = rgb_q;
   assign bus.lcd_oe      = oe_q;
   assign bus.lcd_bl      = bl_q;

endmodule

// File: tb/tb_lcd_rgb_driver.sv
// Self-checking bench for lcd_rgb_driver: cycle-level reference model derived from the
// panel timing table, random pixel data and ID changes, mid-line resets.
module tb_lcd_rgb_driver;

   localparam int DfltHd = 480;
   localparam int DfltVd = 272;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] panel_id = 3'b000;

   lcd_rgb_driver_if bus ();

   lcd_rgb_driver #(
      .ID_WAIT    (8),
      .DEFAULT_ID (3'b000)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .panel_id (panel_id),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int m_hs, m_hb, m_hd, m_hf, m_vs, m_vb, m_vd, m_vf;
   int mon_hs_low, mon_vs_low, mon_de, mon_first_req, mon_hs_fall0, mon_hs_fall1;
   logic [21:0] mon_first_xy;

   task automatic check_eq(input string tag, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [79:0] snap();
      return {13'd0, bus.data_req, bus.pixel_xpos, bus.pixel_ypos, bus.h_disp, bus.v_disp,
              bus.frame_start, bus.lcd_hs, bus.lcd_vs, bus.lcd_de, bus.lcd_rgb,
              bus.lcd_oe, bus.lcd_bl};
   endfunction

   task automatic set_model(input logic [2:0] id);
      case (id)
         3'b001, 3'b100: begin
            m_hs = 128; m_hb = 88;  m_hd = 800;  m_hf = 40;
            m_vs = 2;   m_vb = 33;  m_vd = 480;  m_vf = 10;
         end
         3'b010: begin
            m_hs = 20;  m_hb = 140; m_hd = 1024; m_hf = 160;
            m_vs = 3;   m_vb = 20;  m_vd = 600;  m_vf = 12;
         end
         3'b101: begin
            m_hs = 10;  m_hb = 80;  m_hd = 1280; m_hf = 70;
            m_vs = 3;   m_vb = 10;  m_vd = 800;  m_vf = 10;
         end
         default: begin
            m_hs = 41;  m_hb = 2;   m_hd = 480;  m_hf = 2;
            m_vs = 10;  m_vb = 2;   m_vd = 272;  m_vf = 2;
         end
      endcase
   endtask

   // Entered #1 after a posedge; reset is sampled on the next edge.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_eq(tag, snap(), {13'd0, 1'b0, 11'd0, 11'd0, 11'(DfltHd), 11'(DfltVd),
                             1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0});
   endtask

   // Period k counts clock periods after reset release; RUN starts at k = 10.
   task automatic run_seq(input logic [2:0] id, input int periods, input bit xpos_data,
                          input logic [2:0] id_after, input int toggle_at);
      int          ht, vt, n, h, v;
      logic        run, req, p_req, p_hs, p_vs, p_fs, prev_hs;
      logic [10:0] ex, ey, e_hd, e_vd;
      logic [15:0] pd, p_pd;
      set_model(id);
      ht = m_hs + m_hb + m_hd + m_hf;
      vt = m_vs + m_vb + m_vd + m_vf;
      mon_hs_low = 0; mon_vs_low = 0; mon_de = 0; mon_first_req = 0;
      mon_hs_fall0 = 0; mon_hs_fall1 = 0; mon_first_xy = '0;
      p_req = 1'b0; p_hs = 1'b1; p_vs = 1'b1; p_fs = 1'b0; p_pd = '0; prev_hs = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      panel_id = id;
      for (int k = 1; k <= periods; k++) begin
         if (k == toggle_at) panel_id = id_after;
         run = (k >= 10);
         n = k - 10;
         h = run ? n % ht : 0;
         v = run ? (n / ht) % vt : 0;
         req = run && (h >= m_hs + m_hb - 1) && (h < m_hs + m_hb + m_hd - 1) &&
               (v >= m_vs + m_vb) && (v < m_vs + m_vb + m_vd);
         ex = req ? 11'(h - (m_hs + m_hb - 1)) : 11'd0;
         ey = req ? 11'(v - (m_vs + m_vb)) : 11'd0;
         e_hd = run ? 11'(m_hd) : 11'(DfltHd);
         e_vd = run ? 11'(m_vd) : 11'(DfltVd);
         pd = (xpos_data && req) ? 16'(ex) : 16'($urandom);
         bus.pixel_data = pd;
         @(negedge clk);
         check_eq($sformatf("cycle id=%0d k=%0d", id, k), snap(),
                  {13'd0, req, ex, ey, e_hd, e_vd, p_fs, p_hs, p_vs, p_req,
                   (p_req ? p_pd : 16'd0), run, run});
         if (!bus.lcd_hs) mon_hs_low++;
         if (!bus.lcd_vs) mon_vs_low++;
         if (bus.lcd_de) mon_de++;
         if (bus.data_req && mon_first_req == 0) begin
            mon_first_req = k;
            mon_first_xy = {bus.pixel_xpos, bus.pixel_ypos};
         end
         if (prev_hs && !bus.lcd_hs) begin
            if (mon_hs_fall0 == 0) mon_hs_fall0 = k;
            else if (mon_hs_fall1 == 0) mon_hs_fall1 = k;
         end
         prev_hs = bus.lcd_hs;
         p_req = req; p_pd = pd;
         p_hs = !(run && h < m_hs);
         p_vs = !(run && v < m_vs);
         p_fs = run && h == 0 && v == 0;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      bus.pixel_data = '0;
      @(posedge clk);
      #1;
      do_reset("reset_initial");

      // 480x272, pixel_data = xpos so lcd_rgb should replay the column index.
      run_seq(3'b000, 10 + 525 * 14, 1'b1, 3'b000, 0);
      check_eq("id000 hs_low_14_lines", 80'(mon_hs_low), 80'(m_hs * 14));
      check_eq("id000 vs_low", 80'(mon_vs_low), 80'(m_vs * 525));
      check_eq("id000 de_2_lines", 80'(mon_de), 80'(m_hd * 2));
      check_eq("id000 line_period", 80'(mon_hs_fall1 - mon_hs_fall0),
               80'(m_hs + m_hb + m_hd + m_hf));
      check_eq("id000 first_req_k", 80'(mon_first_req),
               80'(10 + (m_vs + m_vb) * 525 + m_hs + m_hb - 1));
      check_eq("id000 first_req_xy", 80'(mon_first_xy), 80'd0);

      do_reset("reset_before_101");
      run_seq(3'b101, 10 + 1440 * 2, 1'b0, 3'b001, 1000);
      check_eq("id101 hs_low", 80'(mon_hs_low), 80'(m_hs * 2));
      check_eq("id101 line_period", 80'(mon_hs_fall1 - mon_hs_fall0), 80'd1440);
      check_eq("id101 vs_low", 80'(mon_vs_low), 80'(((m_vs < 2) ? m_vs : 2) * 1440));
      check_eq("id101 no_de", 80'(mon_de), 80'd0);
      check_eq("id101 hdisp_after_toggle", 80'(bus.h_disp), 80'd1280);
      check_eq("id101 vdisp_after_toggle", 80'(bus.v_disp), 80'd800);

      do_reset("reset_before_010");
      run_seq(3'b010, 10 + 1344 * 2, 1'b0, 3'b010, 0);
      check_eq("id010 hs_low", 80'(mon_hs_low), 80'(m_hs * 2));
      check_eq("id010 line_period", 80'(mon_hs_fall1 - mon_hs_fall0),
               80'(m_hs + m_hb + m_hd + m_hf));

      // Unknown code, stopped at a random point inside an active line.
      do_reset("reset_before_111");
      run_seq(3'b111, 10 + 525 * 12 + 100 + int'($urandom_range(0, 400)), 1'b1, 3'b011,
              int'($urandom_range(20, 4000)));
      check_eq("id111 line_period", 80'(mon_hs_fall1 - mon_hs_fall0), 80'd525);
      check_eq("id111 hdisp_default", 80'(bus.h_disp), 80'd480);
      do_reset("reset_mid_line");

      run_seq(3'b100, 10 + 900, 1'b0, 3'b100, 0);
      check_eq("id100 hs_low", 80'(mon_hs_low), 80'(m_hs));
      check_eq("id100 hdisp", 80'(bus.h_disp), 80'd800);
      do_reset("reset_final");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lcd_rgb_driver.md
Name: lcd_rgb_driver

Overview:
Drives the parallel RGB565 LCD panel bus: sync/DE timing, pixel data output and backlight. After reset it keeps the RGB bus released so the panel's ID strap bits (R7/G7/B7) can be sampled by the ID reader. It then latches the 3-bit panel ID and selects the matching timing set. It sits between the frame-buffer read path (pixel requester) and the LCD pins.

Parameters:
ID_WAIT, 8, cycles after reset during which the bus stays released (lcd_oe=0); minimum 2.
DEFAULT_ID, 3'b000, ID code used when the latched ID has no timing-table entry.

Ports:
clk  in  1  LCD pixel clock; the panel's DCLK is driven externally from the same clock.
rst  in  1  synchronous reset, active-high.
panel_id  in  3  ID code from the ID reader ({B7,G7,R7} straps); sampled once only.
pixel_data  in  16  RGB565 pixel; valid in the same cycle as data_req.
data_req  out  1  pixel request, issued one cycle ahead of lcd_de.
pixel_xpos  out  11  column of the requested pixel (0 when data_req=0).
pixel_ypos  out  11  row of the requested pixel (0 when data_req=0).
h_disp  out  11  active width of the selected timing.
v_disp  out  11  active height of the selected timing.
frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0.
lcd_hs  out  1  HSYNC, active-low.
lcd_vs  out  1  VSYNC, active-low.
lcd_de  out  1  data enable, active-high.
lcd_rgb  out  16  pixel bus, valid when lcd_oe=1.
lcd_oe  out  1  bus output enable; the pad drives lcd_rgb only when this is 1.
lcd_bl  out  1  backlight enable.

Behaviour:
- Reset (synchronous, active-high, takes effect at any time including mid-frame): state is WAIT and the wait counter is 0. Outputs: lcd_oe=0, lcd_bl=0, lcd_hs=1, lcd_vs=1, lcd_de=0, lcd_rgb=0, data_req=0, frame_start=0, xpos=ypos=0. h_disp and v_disp take the DEFAULT_ID values.
- FSM WAIT -> LATCH -> RUN.
  - WAIT: counts ID_WAIT cycles, then goes to LATCH.
  - LATCH (1 cycle): registers panel_id and loads the timing registers (HS, HB, HD, HF, VS, VB, VD, VF). Unknown codes load the DEFAULT_ID timing. Goes to RUN with h_cnt=v_cnt=0.
  - RUN: lcd_oe=1 and lcd_bl=1 from the first RUN cycle.
- There is no other exit from RUN. Changes on panel_id after LATCH are ignored until the next reset.
- Timing table (HS,HB,HD,HF / VS,VB,VD,VF):
  - 000 (4.3" 480x272): 41,2,480,2 / 10,2,272,2
  - 001 (7" 800x480): 128,88,800,40 / 2,33,480,10
  - 010 (7" 1024x600): 20,140,1024,160 / 3,20,600,12
  - 100 (4.3" 800x480): same as 001
  - 101 (10.1" 1280x800): 10,80,1280,70 / 3,10,800,10
  - all other codes: DEFAULT_ID entry.
- Totals: H_TOTAL=HS+HB+HD+HF and V_TOTAL=VS+VB+VD+VF. h_cnt wraps at H_TOTAL-1 to 0. On that wrap v_cnt increments, and it wraps at V_TOTAL-1.
- All counters are 11 bits. Totals are at most 1440; the design must not overflow.
- Combinational data_req = RUN & (HS+HB-1 <= h_cnt < HS+HB+HD-1) & (VS+VB <= v_cnt < VS+VB+VD).
  - pixel_xpos = h_cnt-(HS+HB-1).
  - pixel_ypos = v_cnt-(VS+VB).
- Registered outputs, one-cycle latency, mutually aligned:
  - lcd_de <= data_req
  - lcd_rgb <= data_req ? pixel_data : 0
  - lcd_hs <= !(h_cnt < HS)
  - lcd_vs <= !(v_cnt < VS)
  - frame_start <= RUN & h_cnt==0 & v_cnt==0
- lcd_rgb is 0 whenever lcd_de=0, including blanking and WAIT/LATCH.

Decomposition:
- Package lcd_timing_pkg holds the timing struct (8 x 11-bit fields), the ID code constants (ID_4342, ID_7084, ID_7016, ID_4384, ID_1018) and a lookup function id_to_timing(id) that returns the DEFAULT_ID entry for unknown codes.
- One sub-module, lcd_hv_counter: h/v counters, wrap logic and the sync/active-window compares, parameterised by the loaded timing.
- The top level holds the FSM, the ID latch and the output registers.

Test Plan:
- Reset with panel_id=000, ID_WAIT=8: lcd_oe=0 for cycles 1-8 after reset release, 0 in LATCH, then 1. h_disp=480, v_disp=272, lcd_bl=1.
- ID 000 frame check:
  - lcd_hs low for 41 cycles every 525.
  - lcd_vs low for 10 lines every 286 lines.
  - lcd_de high for exactly 480 cycles per line on 272 lines.
  - first data_req at h_cnt=42, v_cnt=12 with xpos=0, ypos=0.
- Latency: pixel_data = xpos at each request -> lcd_rgb shows 0..479 one cycle after each data_req, and 0 when lcd_de=0.
- panel_id=101 -> h_disp=1280, v_disp=800, line period 1440 cycles, lcd_hs low for 10 cycles. Toggling panel_id to 001 mid-frame -> no timing change.
- panel_id=111 (unknown) -> 480x272 timing. Reset asserted mid-line -> next cycle lcd_oe=0, lcd_de=0, lcd_hs=1, and the WAIT sequence restarts.
